// File: rtl/module_keypad_scanner_if.sv
// Key handshake bundle between the keypad scanner (master) and the key consumer (slave).
interface module_keypad_scanner_if;
    logic [3:0] key_code_o;
    logic       key_valid_o;
    logic       key_pressed_o;
    logic       overrun_o;
    logic       key_ack_i;

    modport master (
        output key_code_o,
        output key_valid_o,
        output key_pressed_o,
        output overrun_o,
        input  key_ack_i
    );

    modport slave (
        input  key_code_o,
        input  key_valid_o,
        input  key_pressed_o,
        input  overrun_o,
        output key_ack_i
    );
endinterface

// File: rtl/module_keypad_scanner.sv
// 4x4 keypad scanner: one-hot column drive, row synchronizer, press/release debounce,
// and a valid/ack handoff of the accepted key code with overrun detection.
module module_keypad_scanner #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                           clk_10Mhz_i,
    input  logic                           reset_n_i,
    input  logic                           scan_tick_i,
    input  logic [3:0]                     row_i,
    output logic [3:0]                     col_o,
    module_keypad_scanner_if.master        key_if
);
    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HOLD
    } state_t;

    localparam logic [3:0] DT = 4'(DEBOUNCE_TICKS);

    state_t     state_q, state_d;
    logic [1:0] col_idx_q, col_idx_d;
    logic [1:0] row_idx_q, row_idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] col_q, col_d;
    logic [3:0] row_meta_q, row_s_q;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       overrun_q, overrun_d;
    logic       accept;
    logic [1:0] row_lo;
    logic [3:0] cnt_inc;

    always_ff @(posedge clk_10Mhz_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            row_meta_q  <= 4'b1111;
            row_s_q     <= 4'b1111;
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            cnt_q       <= 4'd0;
            col_q       <= 4'b1110;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            row_meta_q  <= row_i;
            row_s_q     <= row_meta_q;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        cnt_inc   = cnt_q + 4'd1;

        // Lowest active row wins when several rows are pulled low together.
        row_lo = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s_q[i]) row_lo = 2'(i);
        end

        if (scan_tick_i) begin
            case (state_q)
                SCAN: begin
                    if (row_s_q == 4'b1111) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_idx_d = row_lo;
                        if (DT == 4'd1) begin
                            accept  = 1'b1;
                            state_d = HOLD;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!row_s_q[row_idx_q]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DT) begin
                            accept  = 1'b1;
                            state_d = HOLD;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        state_d   = SCAN;
                        cnt_d     = 4'd0;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                HOLD: begin
                    // cnt counts consecutive released ticks; any pressed tick restarts it.
                    if (row_s_q[row_idx_q]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DT) begin
                            state_d   = SCAN;
                            cnt_d     = 4'd0;
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        col_d = ~(4'b0001 << col_idx_d);

        // An accept outranks a same-cycle ack, so the new code is never lost.
        key_code_d  = accept ? {row_idx_d, col_idx_q} : key_code_q;
        key_valid_d = accept | (key_valid_q & ~key_if.key_ack_i);
        overrun_d   = accept & key_valid_q & ~key_if.key_ack_i;
    end

    assign col_o                = col_q;
    assign key_if.key_code_o    = key_code_q;
    assign key_if.key_valid_o   = key_valid_q;
    assign key_if.key_pressed_o = (state_q == HOLD);
    assign key_if.overrun_o     = overrun_q;
endmodule

// File: tb/tb_module_keypad_scanner.sv
// Directed and randomized checks of the keypad scanner against a cycle-level behavioural model.
module tb_module_keypad_scanner;
    localparam int DT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       scan_tick = 1'b0;
    logic [3:0] row = 4'hF;
    logic [3:0] col;

    module_keypad_scanner_if key_if();

    module_keypad_scanner #(.DEBOUNCE_TICKS(DT)) dut (
        .clk_10Mhz_i (clk),
        .reset_n_i   (rst_n),
        .scan_tick_i (scan_tick),
        .row_i       (row),
        .col_o       (col),
        .key_if      (key_if)
    );

    always #50 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: plain integers, state 0=scanning, 1=debouncing, 2=held.
    logic [3:0] m_s1, m_s2;
    int m_state, m_col, m_row, m_cnt, m_code;
    bit m_valid, m_ovr;

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF;
        m_state = 0; m_col = 0; m_row = 0; m_cnt = 0; m_code = 0;
        m_valid = 0; m_ovr = 0;
    endtask

    task automatic model_step(input logic t, input logic ack);
        logic [3:0] rs;
        bit acc;
        rs = m_s2; m_s2 = m_s1; m_s1 = row;
        acc = 0; m_ovr = 0;
        if (t) begin
            if (m_state == 0) begin
                if (rs == 4'hF) m_col = (m_col + 1) % 4;
                else begin
                    m_row = 0;
                    while (rs[m_row]) m_row++;
                    if (DT == 1) begin acc = 1; m_state = 2; m_cnt = 0; end
                    else begin m_cnt = 1; m_state = 1; end
                end
            end else if (m_state == 1) begin
                if (!rs[m_row]) begin
                    m_cnt++;
                    if (m_cnt == DT) begin acc = 1; m_state = 2; m_cnt = 0; end
                end else begin
                    m_state = 0; m_cnt = 0; m_col = (m_col + 1) % 4;
                end
            end else begin
                if (rs[m_row]) begin
                    m_cnt++;
                    if (m_cnt == DT) begin m_state = 0; m_cnt = 0; m_col = (m_col + 1) % 4; end
                end else m_cnt = 0;
            end
        end
        if (acc) begin
            m_ovr   = m_valid && !ack;
            m_code  = m_row * 4 + m_col;
            m_valid = 1;
        end else if (ack) m_valid = 0;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] col_of(input int c);
        logic [3:0] e;
        e = 4'b0001 << c;
        return ~e;
    endfunction

    task automatic check_all();
        check("col_o", col, col_of(m_col));
        check("key_code", key_if.key_code_o, 4'(m_code));
        check("key_valid", {3'b0, key_if.key_valid_o}, {3'b0, m_valid});
        check("key_pressed", {3'b0, key_if.key_pressed_o}, {3'b0, m_state == 2});
        check("overrun", {3'b0, key_if.overrun_o}, {3'b0, m_ovr});
    endtask

    task automatic cyc(input logic t, input logic ack);
        scan_tick = t;
        key_if.key_ack_i = ack;
        @(posedge clk);
        model_step(t, ack);
        #1;
        check_all();
        scan_tick = 1'b0;
        key_if.key_ack_i = 1'b0;
    endtask

    // Two quiet cycles before each tick let the synchronizer settle on the current row value.
    task automatic tick_n(input int n);
        repeat (n) begin cyc(0, 0); cyc(0, 0); cyc(1, 0); end
    endtask

    task automatic goto_col(input int c);
        row = 4'hF;
        for (int k = 0; k < 8 && m_col != c; k++) tick_n(1);
        check("goto_col", col, col_of(c));
    endtask

    logic [3:0] idle_exp [5];

    initial begin
        idle_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
        key_if.key_ack_i = 1'b0;
        model_reset();

        // Reset values
        #20 rst_n = 1'b0;
        #5;
        check("rst_col", col, 4'b1110);
        check("rst_code", key_if.key_code_o, 4'd0);
        check("rst_valid", {3'b0, key_if.key_valid_o}, 4'd0);
        check("rst_pressed", {3'b0, key_if.key_pressed_o}, 4'd0);
        check("rst_overrun", {3'b0, key_if.overrun_o}, 4'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();

        // Idle scan
        for (int i = 0; i < 5; i++) begin
            tick_n(1);
            check("idle_col", col, idle_exp[i]);
        end

        // Clean press: row 2 at column 1 -> code 9
        goto_col(1);
        row = 4'b1011;
        tick_n(4);
        check("press_code", key_if.key_code_o, 4'd9);
        check("press_valid", {3'b0, key_if.key_valid_o}, 4'd1);
        check("press_col", col, 4'b1101);
        repeat (3) cyc(0, 0);
        cyc(0, 1);
        check("ack_valid", {3'b0, key_if.key_valid_o}, 4'd0);
        row = 4'hF;
        tick_n(4);

        // Rows 1 and 2 low at column 1 -> code 5
        goto_col(1);
        row = 4'b1001;
        tick_n(4);
        check("multi_code", key_if.key_code_o, 4'd5);
        cyc(0, 1);
        row = 4'hF;
        tick_n(4);

        // Bounce at column 3
        goto_col(3);
        row = 4'b1110;
        tick_n(2);
        row = 4'hF;
        tick_n(1);
        check("bounce_col", col, 4'b1110);
        check("bounce_valid", {3'b0, key_if.key_valid_o}, 4'd0);

        // Overrun: key 0 un-acked, then key 15
        row = 4'b1110;
        tick_n(4);
        check("k0_code", key_if.key_code_o, 4'd0);
        row = 4'hF;
        tick_n(4);
        goto_col(3);
        row = 4'b0111;
        tick_n(4);
        check("ovr_pulse", {3'b0, key_if.overrun_o}, 4'd1);
        check("ovr_code", key_if.key_code_o, 4'd15);
        cyc(0, 0);
        check("ovr_one_cycle", {3'b0, key_if.overrun_o}, 4'd0);

        // Accept coinciding with ack
        row = 4'hF;
        tick_n(4);
        goto_col(3);
        row = 4'b0111;
        tick_n(3);
        cyc(0, 0); cyc(0, 0); cyc(1, 1);
        check("coin_overrun", {3'b0, key_if.overrun_o}, 4'd0);
        check("coin_valid", {3'b0, key_if.key_valid_o}, 4'd1);
        check("coin_code", key_if.key_code_o, 4'd15);

        // Release debounce
        cyc(0, 1);
        row = 4'hF;
        tick_n(2);
        check("rel_held1", {3'b0, key_if.key_pressed_o}, 4'd1);
        row = 4'b0111;
        tick_n(1);
        row = 4'hF;
        tick_n(3);
        check("rel_held2", {3'b0, key_if.key_pressed_o}, 4'd1);
        tick_n(1);
        check("rel_done", {3'b0, key_if.key_pressed_o}, 4'd0);
        check("rel_col", col, 4'b1110);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0)
                row = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        end

        // Asynchronous reset mid-HOLD with a pending key
        row = 4'hF;
        tick_n(16);
        goto_col(2);
        row = 4'b1101;
        tick_n(4);
        check("pre_rst_valid", {3'b0, key_if.key_valid_o}, 4'd1);
        check("pre_rst_pressed", {3'b0, key_if.key_pressed_o}, 4'd1);
        #10 rst_n = 1'b0;
        #1;
        check("arst_col", col, 4'b1110);
        check("arst_valid", {3'b0, key_if.key_valid_o}, 4'd0);
        check("arst_pressed", {3'b0, key_if.key_pressed_o}, 4'd0);
        check("arst_code", key_if.key_code_o, 4'd0);
        row = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        tick_n(1);
        check("post_rst_col", col, 4'b1101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/module_keypad_scanner.md
# module_keypad_scanner

Scan controller for the 4x4 matrix keypad. It is paced by the single-cycle enable pulse from the system clock divider. It drives the keypad columns one at a time, synchronizes and debounces the row lines, and hands each debounced key press to downstream logic through a valid/ack handshake. It sits between the keypad pins and the key-consuming logic, in the 10 MHz clock domain.

## Interface
- DEBOUNCE_TICKS, 4: consecutive scan ticks a row must read stable before a press or release is accepted; legal range 1–15.
- clk_10Mhz_i  input  1  system clock, 10 MHz.
- reset_n_i  input  1  reset; asynchronous, active-low.
- scan_tick_i  input  1  scan enable; every cycle it is high counts as one tick.
- row_i  input  4  keypad rows, active-low, asynchronous to the clock.
- key_ack_i  input  1  consumer acknowledge; clears key_valid_o.
- col_o  output  4  column drive, active-low one-hot.
- key_code_o  output  4  code of the last accepted key: row_idx*4 + col_idx.
- key_valid_o  output  1  a new key code is pending.
- key_pressed_o  output  1  high while an accepted key is held (state HOLD).
- overrun_o  output  1  one-cycle pulse when a pending code is overwritten.

## Operation
- row_i passes through a 2-FF synchronizer, giving row_s. Both synchronizer stages reset to 4'b1111.
- Registers:
  - col_idx: 2 bits.
  - row_idx: 2 bits.
  - cnt: 4 bits.
  - FSM states: SCAN, DEBOUNCE, HOLD.
- col_o is registered and equals ~(4'b0001 << col_idx).
- SCAN, on a tick:
  - If row_s == 4'b1111: col_idx increments mod 4.
  - Otherwise: row_idx is set to the lowest-index low bit of row_s (lowest row wins), cnt is set to 1, and the FSM goes to DEBOUNCE. The column stays frozen.
  - If DEBOUNCE_TICKS == 1, the FSM goes directly to HOLD and accepts the key on the detection tick.
- DEBOUNCE, on a tick:
  - If row_s[row_idx] == 0: cnt increments. When cnt reaches DEBOUNCE_TICKS, the key is accepted and the FSM goes to HOLD with cnt cleared.
  - If row_s[row_idx] == 1: the FSM returns to SCAN, cnt is cleared, and col_idx increments.
- HOLD, on a tick:
  - If row_s[row_idx] == 1: cnt increments. When cnt reaches DEBOUNCE_TICKS, the FSM goes to SCAN, cnt is cleared, and col_idx increments.
  - If row_s[row_idx] == 0: cnt is cleared.
  - Other rows and columns are ignored in HOLD.
- Key accept:
  - key_code_o is loaded with {row_idx, col_idx}.
  - key_valid_o is set to 1.
  - If key_valid_o was already 1 and key_ack_i is 0 in that cycle, overrun_o pulses for 1 cycle.
- Handshake:
  - key_valid_o stays high until a cycle in which key_ack_i = 1, then clears on the next edge.
  - An ack while valid = 0 has no effect.
  - Accept and ack in the same cycle: the accept wins. valid stays 1, the code is updated, and overrun_o stays 0.
- key_code_o holds its value after ack until the next accept.

## Timing
- Reset values:
  - col_o = 4'b1110.
  - key_code_o = 0, key_valid_o = 0, key_pressed_o = 0, overrun_o = 0.
  - State = SCAN, col_idx = 0, row_idx = 0, cnt = 0.
- Reset mid-operation (any state): all outputs take their reset values immediately, without waiting for a clock edge. Scanning restarts at column 0.
- The column changes on the edge following a tick, so each column is driven for one full tick period before it is sampled.
- row_i must be stable for 2 cycles before a tick to be seen on that tick (synchronizer latency).
- Latency from the detection tick to key_valid_o = 1 is (DEBOUNCE_TICKS − 1) ticks plus 1 clock cycle.
- key_pressed_o and key_valid_o rise in the same cycle. key_pressed_o falls on the edge after the DEBOUNCE_TICKS-th consecutive released tick.
- With no ticks, the FSM, counters and columns hold; only the handshake and the synchronizer run.

## Test plan
- Reset:
  - Stimulus: assert reset_n_i = 0 mid-HOLD with valid = 1.
  - Required: same cycle, col_o = 1110, valid = 0, key_pressed_o = 0, code = 0. After release and the first tick, col_o = 1101.
- Idle scan:
  - Stimulus: row_i = 1111, 5 ticks.
  - Required: col_o goes 1110 → 1101 → 1011 → 0111 → 1110, each change one cycle after its tick. valid stays 0.
- Clean press (DEBOUNCE_TICKS = 4):
  - Stimulus: row 2 low only while column 1 is driven, held for 4 ticks; then ack after 3 cycles.
  - Required: col_o frozen at 1101. key_code_o = 9, valid = 1, and key_pressed_o = 1 one cycle after the 4th tick. valid = 0 one cycle after ack.
  - Same stimulus with rows 1 and 2 both low: code = 5.
- Bounce:
  - Stimulus: row 0 low for 2 ticks at column 3, then high.
  - Required: no valid. The FSM returns to SCAN and col_o goes to 1110.
- Overrun and coincidence:
  - Stimulus: accept key 0, no ack; release it; accept key 15.
  - Required: overrun_o is a 1-cycle pulse and code = 15.
  - Repeat with ack asserted in the accept cycle. Required: overrun_o = 0, valid = 1, code = 15.
- Release debounce:
  - Stimulus: in HOLD, row goes high 2 ticks, low 1 tick, then high 4 ticks.
  - Required: key_pressed_o stays 1 until the 4th consecutive high tick, then 0. Scanning resumes at the next column.
